// File: rtl/ws2812_pkg.sv
// Shared constants for the WS2812 frame controller: pixel width, default
// bit timing at 48 MHz, FSM state encodings and a small sizing helper.
package ws2812_pkg;

    localparam int PIX_W = 24;

    localparam int DEF_NUM_LEDS    = 8;
    localparam int DEF_T0H_TICKS   = 17;
    localparam int DEF_T1H_TICKS   = 34;
    localparam int DEF_TBIT_TICKS  = 60;
    localparam int DEF_RESET_TICKS = 2880;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FIRST = 2'd1;
    localparam state_t ST_BIT   = 2'd2;
    localparam state_t ST_LATCH = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Bit-period timer and line driver. One tick counter serves both the bit
// period and the latch gap; the controller restarts it with load_i.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_TICKS   = DEF_T0H_TICKS,
    parameter int T1H_TICKS   = DEF_T1H_TICKS,
    parameter int TBIT_TICKS  = DEF_TBIT_TICKS,
    parameter int RESET_TICKS = DEF_RESET_TICKS
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic bit_i,
    input  logic drive_i,
    output logic led_o,
    output logic bit_done_o,
    output logic gap_done_o
);

    localparam int TICK_MAX = max_int(TBIT_TICKS, RESET_TICKS) - 1;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [TICK_W-1:0] T0H_L     = TICK_W'(T0H_TICKS);
    localparam logic [TICK_W-1:0] T1H_L     = TICK_W'(T1H_TICKS);
    localparam logic [TICK_W-1:0] TBIT_LAST = TICK_W'(TBIT_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(RESET_TICKS - 1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic [TICK_W-1:0] thr_s;
    logic              led_q;
    logic              led_d;

    // Next tick and the line level that goes with it; bit_i/drive_i describe the next cycle
    always_comb begin
        tick_d = tick_q;
        thr_s  = T0H_L;
        if (load_i) begin
            tick_d = {TICK_W{1'b0}};
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
        if (bit_i) begin
            thr_s = T1H_L;
        end else begin
            thr_s = T0H_L;
        end
        led_d = drive_i && (tick_d < thr_s);
    end

    // Tick counter and registered line output
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_q <= {TICK_W{1'b0}};
            led_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            led_q  <= led_d;
        end
    end

    assign led_o      = led_q;
    assign bit_done_o = (tick_q == TBIT_LAST);
    assign gap_done_o = (tick_q == GAP_LAST);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: accepts GRB words over valid/ready into a
// shift register plus one holding buffer and sequences a whole frame.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = DEF_NUM_LEDS,
    parameter int T0H_TICKS   = DEF_T0H_TICKS,
    parameter int T1H_TICKS   = DEF_T1H_TICKS,
    parameter int TBIT_TICKS  = DEF_TBIT_TICKS,
    parameter int RESET_TICKS = DEF_RESET_TICKS,
    localparam int IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_pix_valid,
    input  logic [23:0]      i_pix_data,
    output logic             o_pix_ready,
    output logic [IDX_W-1:0] o_pix_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_led
);

    localparam int                CNT_W    = $clog2(NUM_LEDS + 1);
    localparam logic [CNT_W-1:0]  NUM_L    = CNT_W'(NUM_LEDS);
    localparam logic [4:0]        BIT_LAST = 5'd23;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   shift_q, shift_d;
    logic [PIX_W-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [4:0]         bit_q, bit_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept_s;
    logic               load_s;
    logic               drive_s;
    logic               bit_done_s;
    logic               gap_done_s;

    assign accept_s = i_pix_valid && ready_q;
    assign drive_s  = (state_d == ST_BIT);

    // Frame sequencing, buffer hand-over and the pixel-boundary decisions
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        err_d       = err_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_s = 1'b1;
                if (i_start) begin
                    state_d     = ST_FIRST;
                    err_d       = 1'b0;
                    acc_d       = {CNT_W{1'b0}};
                    hold_full_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                load_s = 1'b1;
                if (accept_s) begin
                    shift_d = i_pix_data;
                    bit_d   = BIT_LAST;
                    acc_d   = acc_q + CNT_W'(1);
                    state_d = ST_BIT;
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_BIT: begin
                if (accept_s) begin
                    hold_d      = i_pix_data;
                    hold_full_d = 1'b1;
                    acc_d       = acc_q + CNT_W'(1);
                end else begin
                    hold_full_d = hold_full_q;
                end
                if (bit_done_s) begin
                    load_s = 1'b1;
                    // A word arriving exactly on the boundary bypasses the holding buffer
                    if (bit_q != 5'd0) begin
                        shift_d = {shift_q[PIX_W-2:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                    end else if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_d       = BIT_LAST;
                    end else if (accept_s) begin
                        shift_d     = i_pix_data;
                        hold_full_d = 1'b0;
                        bit_d       = BIT_LAST;
                    end else if (acc_q == NUM_L) begin
                        state_d = ST_LATCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_LATCH;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_LATCH: begin
                if (gap_done_s) begin
                    load_s  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                load_s  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        ready_d = !hold_full_d && (acc_d < NUM_L) &&
                  ((state_d == ST_FIRST) || (state_d == ST_BIT));
        busy_d  = (state_d != ST_IDLE);
    end

    // State, buffers and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= {PIX_W{1'b0}};
            hold_q      <= {PIX_W{1'b0}};
            hold_full_q <= 1'b0;
            bit_q       <= 5'd0;
            acc_q       <= {CNT_W{1'b0}};
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    ws2812_bit_tx #(
        .T0H_TICKS   (T0H_TICKS),
        .T1H_TICKS   (T1H_TICKS),
        .TBIT_TICKS  (TBIT_TICKS),
        .RESET_TICKS (RESET_TICKS)
    ) u_bit_tx (
        .clk_i      (i_clk),
        .rst_n_i    (i_rst_n),
        .load_i     (load_s),
        .bit_i      (shift_d[PIX_W-1]),
        .drive_i    (drive_s),
        .led_o      (o_led),
        .bit_done_o (bit_done_s),
        .gap_done_o (gap_done_s)
    );

    assign o_pix_ready = ready_q;
    assign o_pix_idx   = acc_q[IDX_W-1:0];
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
